// File: rtl/mul_ctrl.sv
// Issue/writeback controller between MDU dispatch and the 3-stage multiplier, one op in flight.
// Latency: multiplied op request T -> mul_valid_o T+1 -> wb_valid_o T+4; zero-operand bypass -> wb_valid_o T+1.
// Backpressure: req_ready_o only in IDLE or when DONE drains; wb_ready_i low holds DONE; result pulse always absorbed in WAIT.
module mul_ctrl #(
  parameter int TAG_WIDTH   = 6,
  parameter int ZERO_BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 a_rst_n,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [1:0]           req_op_i,
  input  logic [31:0]          req_src0_i,
  input  logic [31:0]          req_src1_i,
  input  logic [TAG_WIDTH-1:0] req_tag_i,
  input  logic [4:0]           req_rd_i,
  output logic                 mul_valid_o,
  input  logic                 mul_ready_i,
  output logic                 mul_signed_o,
  output logic [31:0]          multiplicand_o,
  output logic [31:0]          multiplier_o,
  input  logic                 mul_res_valid_i,
  output logic                 mul_res_ready_o,
  input  logic [63:0]          mul_res_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [31:0]          wb_data_o,
  output logic [TAG_WIDTH-1:0] wb_tag_o,
  output logic [4:0]           wb_rd_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t               state;
  logic [1:0]           op;
  logic [TAG_WIDTH-1:0] tag;
  logic [4:0]           rd;
  logic                 accept;
  logic                 bypass;
  logic                 high_word;

  // A new op enters when idle, or in the same cycle the finished op drains (no bubble); flush blocks entry.
  assign req_ready_o  = !flush_i && ((state == IDLE) || ((state == DONE) && wb_ready_i));
  assign accept       = req_valid_i && req_ready_o;
  assign bypass       = (ZERO_BYPASS != 0) && ((req_src0_i == 32'd0) || (req_src1_i == 32'd0));
  // Only MULH.WU is unsigned; reserved encoding behaves as MUL.W.
  assign mul_signed_o = (op != 2'b10);
  assign high_word    = (op == 2'b01) || (op == 2'b10);

  // Controller FSM with registered handshake outputs and result holding registers.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state           <= IDLE;
      mul_valid_o     <= 1'b0;
      mul_res_ready_o <= 1'b0;
      wb_valid_o      <= 1'b0;
      wb_data_o       <= '0;
      wb_tag_o        <= '0;
      wb_rd_o         <= '0;
      op              <= '0;
      multiplicand_o  <= '0;
      multiplier_o    <= '0;
      tag             <= '0;
      rd              <= '0;
    end else if (flush_i) begin
      state           <= IDLE;
      mul_valid_o     <= 1'b0;
      mul_res_ready_o <= 1'b0;
      wb_valid_o      <= 1'b0;
      wb_data_o       <= '0;
      wb_tag_o        <= '0;
      wb_rd_o         <= '0;
      op              <= '0;
      multiplicand_o  <= '0;
      multiplier_o    <= '0;
      tag             <= '0;
      rd              <= '0;
    end else begin
      case (state)
        IDLE: begin
        end
        ISSUE: begin
          if (mul_ready_i) begin
            state           <= WAIT;
            mul_valid_o     <= 1'b0;
            mul_res_ready_o <= 1'b1;
          end
        end
        WAIT: begin
          if (mul_res_valid_i) begin
            state           <= DONE;
            mul_res_ready_o <= 1'b0;
            wb_valid_o      <= 1'b1;
            wb_data_o       <= high_word ? mul_res_i[63:32] : mul_res_i[31:0];
            wb_tag_o        <= tag;
            wb_rd_o         <= rd;
          end
        end
        DONE: begin
          if (wb_ready_i) begin
            state      <= IDLE;
            wb_valid_o <= 1'b0;
          end
        end
      endcase
      // Capture overrides the drain above so DONE can hand straight over to the next op.
      if (accept) begin
        op             <= req_op_i;
        multiplicand_o <= req_src0_i;
        multiplier_o   <= req_src1_i;
        tag            <= req_tag_i;
        rd             <= req_rd_i;
        if (bypass) begin
          state       <= DONE;
          mul_valid_o <= 1'b0;
          wb_valid_o  <= 1'b1;
          wb_data_o   <= 32'd0;
          wb_tag_o    <= req_tag_i;
          wb_rd_o     <= req_rd_i;
        end else begin
          state       <= ISSUE;
          mul_valid_o <= 1'b1;
          wb_valid_o  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
module tb_mul_ctrl;

  logic        clk, a_rst_n, flush, req_valid, mul_rdy, wb_ready, junk;
  logic [1:0]  req_op;
  logic [31:0] src0, src1, junk_dat;
  logic [5:0]  req_tag;
  logic [4:0]  req_rd;

  logic        req_ready, mul_valid, mul_signed, res_ready, wb_valid, res_vld;
  logic [31:0] mcand, mplier, wb_data;
  logic [5:0]  wb_tag;
  logic [4:0]  wb_rd;
  logic [63:0] res_dat;

  logic        nb_req_ready, nb_mul_valid, nb_mul_signed, nb_res_ready, nb_wb_valid, nb_res_vld;
  logic [31:0] nb_mcand, nb_mplier, nb_wb_data;
  logic [5:0]  nb_wb_tag;
  logic [4:0]  nb_wb_rd;
  logic [63:0] nb_res_dat;

  int n_cmp = 0;
  int n_bad = 0;

  mul_ctrl #(.TAG_WIDTH(6), .ZERO_BYPASS(1)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_src0_i(src0), .req_src1_i(src1), .req_tag_i(req_tag), .req_rd_i(req_rd),
    .mul_valid_o(mul_valid), .mul_ready_i(mul_rdy), .mul_signed_o(mul_signed),
    .multiplicand_o(mcand), .multiplier_o(mplier),
    .mul_res_valid_i(res_vld), .mul_res_ready_o(res_ready), .mul_res_i(res_dat),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_data_o(wb_data),
    .wb_tag_o(wb_tag), .wb_rd_o(wb_rd)
  );

  mul_ctrl #(.TAG_WIDTH(6), .ZERO_BYPASS(0)) dut_nb (
    .clk(clk), .a_rst_n(a_rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(nb_req_ready), .req_op_i(req_op),
    .req_src0_i(src0), .req_src1_i(src1), .req_tag_i(req_tag), .req_rd_i(req_rd),
    .mul_valid_o(nb_mul_valid), .mul_ready_i(1'b1), .mul_signed_o(nb_mul_signed),
    .multiplicand_o(nb_mcand), .multiplier_o(nb_mplier),
    .mul_res_valid_i(nb_res_vld), .mul_res_ready_o(nb_res_ready), .mul_res_i(nb_res_dat),
    .wb_valid_o(nb_wb_valid), .wb_ready_i(wb_ready), .wb_data_o(nb_wb_data),
    .wb_tag_o(nb_wb_tag), .wb_rd_o(nb_wb_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
    $fatal(1);
  end

  function automatic logic [63:0] prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (sgn) return 64'(sa * sb);
    return ua * ub;
  endfunction

  // Three-stage multiplier stand-ins: result pulse two cycles after the issue handshake.
  logic        p1, p2, n1, n2;
  logic [63:0] q1, q2, nq1, nq2;
  always @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      p1 <= 1'b0; p2 <= 1'b0; q1 <= '0; q2 <= '0;
      n1 <= 1'b0; n2 <= 1'b0; nq1 <= '0; nq2 <= '0;
    end else if (flush) begin
      p1 <= 1'b0; p2 <= 1'b0; n1 <= 1'b0; n2 <= 1'b0;
    end else begin
      p1 <= mul_valid && mul_rdy;
      q1 <= prod(mul_signed, mcand, mplier);
      p2 <= p1;
      q2 <= q1;
      n1 <= nb_mul_valid;
      nq1 <= prod(nb_mul_signed, nb_mcand, nb_mplier);
      n2 <= n1;
      nq2 <= nq1;
    end
  end
  // Spurious pulses only appear while no real result is pending, i.e. outside WAIT.
  assign res_vld    = p2 | (junk & ~p1 & ~p2);
  assign res_dat    = p2 ? q2 : {junk_dat, ~junk_dat};
  assign nb_res_vld = n2;
  assign nb_res_dat = nq2;

  // Transaction-level reference: which op is held and how far along it is.
  bit          m_busy, m_issued, m_done, m_opclr, m_wbclr;
  logic [1:0]  m_op;
  logic [31:0] m_a, m_b, m_data;
  logic [5:0]  m_tag, m_wtag;
  logic [4:0]  m_rd, m_wrd;

  function automatic logic [31:0] pick(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = prod(op != 2'd2, a, b);
    return (op == 2'd1 || op == 2'd2) ? full[63:32] : full[31:0];
  endfunction

  function automatic bit exp_rr();
    return !flush && (!m_busy || (m_done && wb_ready));
  endfunction

  task automatic model_clear();
    m_busy = 0; m_issued = 0; m_done = 0; m_opclr = 1; m_wbclr = 1;
    m_op = '0; m_a = '0; m_b = '0; m_data = '0; m_tag = '0; m_wtag = '0; m_rd = '0; m_wrd = '0;
  endtask

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  task automatic check_outputs();
    bit emv;
    emv = m_busy && !m_done && !m_issued;
    cmp("req_ready", req_ready, exp_rr());
    cmp("mul_valid", mul_valid, emv);
    cmp("res_ready", res_ready, m_busy && m_issued && !m_done);
    cmp("wb_valid", wb_valid, m_done);
    if (emv) cmp("mul_signed", mul_signed, m_op != 2'd2);
    if (emv || m_opclr) begin
      cmp("multiplicand", mcand, m_a);
      cmp("multiplier", mplier, m_b);
    end
    if (m_done || m_wbclr) begin
      cmp("wb_data", wb_data, m_data);
      cmp("wb_tag", wb_tag, m_wtag);
      cmp("wb_rd", wb_rd, m_wrd);
    end
  endtask

  task automatic model_update();
    bit acc;
    if (!a_rst_n || flush) begin
      model_clear();
    end else begin
      acc = req_valid && exp_rr();
      if (m_done) begin
        if (wb_ready) begin m_busy = 0; m_done = 0; end
      end else if (m_busy && !m_issued) begin
        if (mul_rdy) m_issued = 1;
      end else if (m_busy && res_vld) begin
        m_done = 1; m_data = pick(m_op, m_a, m_b); m_wtag = m_tag; m_wrd = m_rd; m_wbclr = 0;
      end
      if (acc) begin
        m_busy = 1; m_issued = 0; m_opclr = 0;
        m_op = req_op; m_a = src0; m_b = src1; m_tag = req_tag; m_rd = req_rd;
        if (src0 == 32'd0 || src1 == 32'd0) begin
          m_done = 1; m_data = '0; m_wtag = req_tag; m_wrd = req_rd; m_wbclr = 0;
        end else begin
          m_done = 0;
        end
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_op = op; src0 = a; src1 = b;
    req_tag = 6'($urandom); req_rd = 5'($urandom);
  endtask

  task automatic do_reset();
    #1 a_rst_n = 1'b0;
    model_clear();
    step();
    step();
    a_rst_n = 1'b1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expd, input int exp_lat, input string nm, output int nb_lat);
    logic [5:0] t;
    logic [4:0] r;
    int lat;
    wb_ready = 1'b1; mul_rdy = 1'b1; junk = 1'b0;
    send(op, a, b);
    t = req_tag; r = req_rd;
    #1 cmp({nm, "_accept"}, req_ready, 1);
    step();
    req_valid = 1'b0;
    lat = -1; nb_lat = -1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) begin
        cmp({nm, "_mv_t1"}, mul_valid, exp_lat > 1);
        if (exp_lat > 1) cmp({nm, "_signed"}, mul_signed, op != 2'b10);
      end
      if (lat < 0 && wb_valid) begin
        lat = k;
        cmp({nm, "_data"}, wb_data, expd);
        cmp({nm, "_tag"}, wb_tag, t);
        cmp({nm, "_rd"}, wb_rd, r);
      end
      if (nb_lat < 0 && nb_wb_valid) nb_lat = k;
      step();
    end
    cmp({nm, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nbl, wbc;
    a_rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; mul_rdy = 1'b1; wb_ready = 1'b1;
    junk = 1'b0; junk_dat = '0; req_op = '0; src0 = '0; src1 = '0; req_tag = '0; req_rd = '0;
    model_clear();
    #3;
    cmp("rst_req_ready", req_ready, 1);
    cmp("rst_mul_valid", mul_valid, 0);
    cmp("rst_wb_valid", wb_valid, 0);
    cmp("rst_wb_data", wb_data, 0);
    cmp("rst_res_ready", res_ready, 0);
    @(posedge clk); #1;
    step();
    a_rst_n = 1'b1;
    step();

    run_op(2'b00, 32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFFE, 4, "mulw", nbl);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4, "mulhw_m1", nbl);
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4, "mulhwu_m1", nbl);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 4, "mulw_m1", nbl);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4, "mulhw_min", nbl);
    run_op(2'b11, 32'h3, 32'h5, 32'hF, 4, "reserved", nbl);
    do_reset();
    run_op(2'b00, 32'h0, 32'h1234_5678, 32'h0, 1, "zbyp", nbl);
    cmp("zbyp_nobypass_lat", 64'(nbl), 4);

    // Writeback back-pressure then back-to-back handover.
    wb_ready = 1'b0;
    send(2'b00, 32'd6, 32'd7);
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 8 && !wb_valid; k++) step();
    for (int k = 0; k < 5; k++) begin
      cmp("bp_wb_valid", wb_valid, 1);
      cmp("bp_wb_data", wb_data, 32'd42);
      cmp("bp_req_ready", req_ready, 0);
      step();
    end
    wb_ready = 1'b1;
    send(2'b00, 32'd9, 32'd9);
    #1 cmp("b2b_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    cmp("b2b_mul_valid", mul_valid, 1);
    cmp("b2b_mcand", mcand, 32'd9);
    repeat (8) step();

    // Flush in ISSUE, WAIT and DONE.
    for (int ph = 0; ph < 3; ph++) begin
      mul_rdy = (ph != 0);
      wb_ready = (ph != 2);
      send(2'b01, 32'd3, 32'd4);
      step();
      req_valid = 1'b0;
      repeat (ph == 0 ? 0 : (ph == 1 ? 1 : 3)) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      cmp("flush_mul_valid", mul_valid, 0);
      cmp("flush_wb_valid", wb_valid, 0);
      cmp("flush_res_ready", res_ready, 0);
      cmp("flush_mcand", mcand, 0);
      cmp("flush_wb_tag", wb_tag, 0);
      mul_rdy = 1'b1; wb_ready = 1'b1;
      wbc = 0;
      for (int k = 0; k < 6; k++) begin
        if (wb_valid) wbc++;
        step();
      end
      cmp("flush_no_wb", 64'(wbc), 0);
    end

    // Flush coinciding with a request.
    flush = 1'b1;
    send(2'b00, 32'd5, 32'd5);
    #1 cmp("flush_req_ready", req_ready, 0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    cmp("flush_req_mv", mul_valid, 0);
    cmp("flush_req_wb", wb_valid, 0);
    step();

    // Asynchronous reset mid-op (in WAIT).
    send(2'b00, 32'd11, 32'd13);
    step();
    req_valid = 1'b0;
    step();
    #1 a_rst_n = 1'b0;
    #1;
    cmp("arst_res_ready", res_ready, 0);
    cmp("arst_mul_valid", mul_valid, 0);
    cmp("arst_mcand", mcand, 0);
    cmp("arst_wb_valid", wb_valid, 0);
    model_clear();
    step();
    a_rst_n = 1'b1;
    step();

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      req_valid = 1'($urandom_range(1));
      req_op = 2'($urandom);
      src0 = rnd_opnd();
      src1 = rnd_opnd();
      req_tag = 6'($urandom);
      req_rd = 5'($urandom);
      mul_rdy = ($urandom_range(3) != 0);
      wb_ready = ($urandom_range(4) < 3);
      flush = ($urandom_range(39) == 0);
      junk = ($urandom_range(7) == 0);
      junk_dat = $urandom;
      step();
    end
    flush = 1'b0; req_valid = 1'b0; junk = 1'b0; wb_ready = 1'b1; mul_rdy = 1'b1;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
